// File: rtl/cpu_pkg.sv
// Shared constants and types for the single-cycle MIPS-subset core.
package cpu_pkg;

  localparam int MEM_DEPTH = 32;
  localparam int MEM_AW    = 5;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_op_e;

endpackage

// File: rtl/cpu_regfile.sv
// 32x32 register file: two combinational read ports, one synchronous write port, $0 hardwired to zero.
module cpu_regfile
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [MEM_AW-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [MEM_AW-1:0] raddr_a,
  input  logic [MEM_AW-1:0] raddr_b,
  output logic [31:0]       rdata_a,
  output logic [31:0]       rdata_b
);

  logic [31:0] regs [MEM_DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MEM_DEPTH; i++) regs[i] <= '0;
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == '0) ? '0 : regs[raddr_a];
  assign rdata_b = (raddr_b == '0) ? '0 : regs[raddr_b];

endmodule

// File: rtl/mips_cpu_top.sv
// Single-cycle MIPS-subset core with loadable instruction memory and data memory.
// Optional debug observation port enabled by defining CPU_DEBUG_PORT_EN.
module mips_cpu_top
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_mem_en,
  input  logic [31:0]       load_mem_data,
  input  logic [MEM_AW-1:0] load_mem_addr
`ifdef CPU_DEBUG_PORT_EN
  ,
  output logic [31:0]       dbg_pc,
  output logic [31:0]       dbg_instr,
  output logic              dbg_rf_we,
  output logic [MEM_AW-1:0] dbg_rf_waddr,
  output logic [31:0]       dbg_rf_wdata
`endif
);

  logic [31:0] imem [MEM_DEPTH];
  logic [31:0] dmem [MEM_DEPTH];
  logic [31:0] pc, pc_plus4, pc_next, instr;
  logic [31:0] rdata_a, rdata_b, alu_b, alu_y, rf_wdata;
  logic signed [31:0] imm_sext;
  logic [5:0]  opcode, funct;
  logic [MEM_AW-1:0] rs, rt, rd, rf_waddr;
  logic        stall, rf_we, rf_we_eff, mem_we, mem_we_eff, wb_mem, branch, jump;
  alu_op_e     alu_op;

  function automatic logic [31:0] alu(input alu_op_e op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] y;
    case (op)
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_SLT: y = {31'b0, ($signed(a) < $signed(b))};
      default: y = a + b;
    endcase
    return y;
  endfunction

  // Instruction memory is never reset so a loaded program survives a reset.
  always_ff @(posedge clk) begin
    if (load_mem_en) imem[load_mem_addr] <= load_mem_data;
  end

  assign stall    = load_mem_en | rst;
  assign instr    = imem[pc[6:2]];
  assign opcode   = instr[31:26];
  assign rs       = instr[25:21];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];
  assign funct    = instr[5:0];
  assign imm_sext = {{16{instr[15]}}, instr[15:0]};

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = rd;
    alu_op   = ALU_ADD;
    alu_b    = rdata_b;
    mem_we   = 1'b0;
    wb_mem   = 1'b0;
    branch   = 1'b0;
    jump     = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        rf_we = 1'b1;
        case (funct)
          FN_ADD:  alu_op = ALU_ADD;
          FN_SUB:  alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_SLT:  alu_op = ALU_SLT;
          default: rf_we  = 1'b0;
        endcase
      end
      OP_ADDI: begin
        rf_we = 1'b1; rf_waddr = rt; alu_b = imm_sext;
      end
      OP_LW: begin
        rf_we = 1'b1; rf_waddr = rt; alu_b = imm_sext; wb_mem = 1'b1;
      end
      OP_SW: begin
        mem_we = 1'b1; alu_b = imm_sext;
      end
      OP_BEQ:  branch = (rdata_a == rdata_b);
      OP_J:    jump = 1'b1;
      default: ;
    endcase
  end

  assign alu_y      = alu(alu_op, rdata_a, alu_b);
  assign rf_wdata   = wb_mem ? dmem[alu_y[6:2]] : alu_y;
  assign rf_we_eff  = rf_we & ~stall & (rf_waddr != '0);
  assign mem_we_eff = mem_we & ~stall;

  assign pc_plus4 = pc + 32'd4;
  assign pc_next  = jump   ? {pc_plus4[31:28], instr[25:0], 2'b00} :
                    branch ? pc_plus4 + {imm_sext[29:0], 2'b00} :
                             pc_plus4;

  // PC is kept inside the 128-byte fetch window; a load pauses it in place.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc <= '0;
    else if (!load_mem_en) pc <= pc_next & 32'h0000_007C;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MEM_DEPTH; i++) dmem[i] <= '0;
    end else if (mem_we_eff) begin
      dmem[alu_y[6:2]] <= rdata_b;
    end
  end

  cpu_regfile u_rf (
    .clk     (clk),
    .rst     (rst),
    .we      (rf_we_eff),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata),
    .raddr_a (rs),
    .raddr_b (rt),
    .rdata_a (rdata_a),
    .rdata_b (rdata_b)
  );

`ifdef CPU_DEBUG_PORT_EN
  assign dbg_pc       = pc;
  assign dbg_instr    = instr;
  assign dbg_rf_we    = rf_we_eff;
  assign dbg_rf_waddr = rf_waddr;
  assign dbg_rf_wdata = rf_wdata;
`endif

endmodule

// File: tb/tb_mips_cpu_top.sv
// Scoreboard testbench for mips_cpu_top: expected per-cycle write-back trace queued by stimulus, checked by a monitor.
module tb_mips_cpu_top;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_mem_en;
  logic [31:0] load_mem_data;
  logic [4:0]  load_mem_addr;

  logic [31:0] obs_pc, obs_instr, obs_wdata;
  logic        obs_we;
  logic [4:0]  obs_waddr;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] pc;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } exp_t;

  exp_t sb[$];

  localparam logic [31:0] NOP_W = 32'hFC00_0000;
  logic [31:0] prog [32];

  always #5 clk = ~clk;

`ifdef CPU_DEBUG_PORT_EN
  logic [31:0] dbg_pc, dbg_instr, dbg_rf_wdata;
  logic        dbg_rf_we;
  logic [4:0]  dbg_rf_waddr;
  mips_cpu_top dut (
    .clk(clk), .rst(rst), .load_mem_en(load_mem_en),
    .load_mem_data(load_mem_data), .load_mem_addr(load_mem_addr),
    .dbg_pc(dbg_pc), .dbg_instr(dbg_instr), .dbg_rf_we(dbg_rf_we),
    .dbg_rf_waddr(dbg_rf_waddr), .dbg_rf_wdata(dbg_rf_wdata)
  );
  assign obs_pc    = dbg_pc;
  assign obs_instr = dbg_instr;
  assign obs_we    = dbg_rf_we;
  assign obs_waddr = dbg_rf_waddr;
  assign obs_wdata = dbg_rf_wdata;
`else
  mips_cpu_top dut (
    .clk(clk), .rst(rst), .load_mem_en(load_mem_en),
    .load_mem_data(load_mem_data), .load_mem_addr(load_mem_addr)
  );
  assign obs_pc    = dut.pc;
  assign obs_instr = dut.instr;
  assign obs_we    = dut.rf_we_eff;
  assign obs_waddr = dut.rf_waddr;
  assign obs_wdata = dut.rf_wdata;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic we, input logic [4:0] wa, input logic [31:0] wd);
    exp_t e;
    e.pc = pc; e.we = we; e.waddr = wa; e.wdata = wd;
    sb.push_back(e);
  endtask

  // Monitor: one trace entry per executing cycle, sampled mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && !load_mem_en && sb.size() > 0) begin
        e = sb.pop_front();
        chk("trace_pc", obs_pc, e.pc);
        chk("trace_we", {31'b0, obs_we}, {31'b0, e.we});
        if (e.we) begin
          chk("trace_waddr", {27'b0, obs_waddr}, {27'b0, e.waddr});
          chk("trace_wdata", obs_wdata, e.wdata);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset asserted, load the whole image, then release reset with load still high.
  task automatic load_image();
    rst = 1'b1;
    load_mem_en = 1'b1;
    for (int i = 0; i < 32; i++) begin
      load_mem_addr = 5'(i);
      load_mem_data = prog[i];
      step();
      if (i % 8 == 7) chk("pc_hold_rst", obs_pc, 32'd0);
    end
    rst = 1'b0;
    step();
    chk("pc_hold_load", obs_pc, 32'd0);
  endtask

  task automatic push_main_trace();
    push(32'd0,  1'b1, 5'd1, 32'd5);
    push(32'd4,  1'b1, 5'd2, 32'd10);
    push(32'd8,  1'b0, 5'd0, 32'd0);
    push(32'd12, 1'b1, 5'd3, 32'd10);
    push(32'd16, 1'b0, 5'd0, 32'd0);
    push(32'd20, 1'b1, 5'd4, 32'd5);
    push(32'd24, 1'b1, 5'd6, 32'hFFFF_FFFF);
    push(32'd28, 1'b1, 5'd5, 32'd1);
    push(32'd32, 1'b1, 5'd7, 32'd10);
    push(32'd36, 1'b1, 5'd8, 32'd15);
    push(32'd40, 1'b0, 5'd0, 32'd0);
    push(32'd52, 1'b0, 5'd0, 32'd0);
    push(32'd56, 1'b0, 5'd0, 32'd0);
    push(32'd60, 1'b0, 5'd0, 32'd0);
    push(32'd20, 1'b1, 5'd4, 32'd5);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    load_mem_en = 1'b0;
    load_mem_data = '0;
    load_mem_addr = '0;
    #2;
    chk("reset_pc", obs_pc, 32'd0);
    chk("reset_we", {31'b0, obs_we}, 32'd0);

    // Sequential fetch and wrap using illegal-opcode NOPs.
    for (int i = 0; i < 32; i++) prog[i] = NOP_W;
    load_image();
    for (int i = 0; i < 34; i++) push(32'((i * 4) % 128), 1'b0, 5'd0, 32'd0);
    load_mem_en = 1'b0;
    repeat (34) step();
    load_mem_en = 1'b1;
    chk("wrap_sb_empty", 32'(sb.size()), 32'd0);

    // Arithmetic, memory, branch and jump program.
    for (int i = 0; i < 32; i++) prog[i] = NOP_W;
    prog[0]  = 32'h2001_0005; // addi $1,$0,5
    prog[1]  = 32'h0021_1020; // add  $2,$1,$1
    prog[2]  = 32'hAC02_0008; // sw   $2,8($0)
    prog[3]  = 32'h8C03_0008; // lw   $3,8($0)
    prog[4]  = 32'h2000_0007; // addi $0,$0,7
    prog[5]  = 32'h0041_2022; // sub  $4,$2,$1
    prog[6]  = 32'h2006_FFFF; // addi $6,$0,-1
    prog[7]  = 32'h00C1_282A; // slt  $5,$6,$1
    prog[8]  = 32'h0046_3824; // and  $7,$2,$6
    prog[9]  = 32'h0022_4025; // or   $8,$1,$2
    prog[10] = 32'h1000_0002; // beq  $0,$0,+2 -> 52
    prog[13] = 32'h0800_000E; // j    14 -> 56
    prog[14] = 32'h1020_0005; // beq  $1,$0,+5 not taken
    prog[15] = 32'h0800_0005; // j    5 -> 20
    load_image();
    push_main_trace();
    load_mem_en = 1'b0;
    repeat (15) step();
    load_mem_en = 1'b1;
    chk("main_sb_empty", 32'(sb.size()), 32'd0);
    chk("reg3_lw", dut.u_rf.regs[3], 32'd10);
    chk("dmem2_sw", dut.dmem[2], 32'd10);
    chk("reg0_zero", dut.u_rf.regs[0], 32'd0);

    // Mid-program load: PC holds, then resumes.
    load_mem_addr = 5'd31;
    load_mem_data = NOP_W;
    step();
    step();
    chk("pc_hold_midload", obs_pc, 32'd24);
    chk("stall_we", {31'b0, obs_we}, 32'd0);
    push(32'd24, 1'b1, 5'd6, 32'hFFFF_FFFF);
    load_mem_en = 1'b0;
    step();

    // Asynchronous reset in the middle of a cycle.
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_pc", obs_pc, 32'd0);
    chk("async_rst_reg1", dut.u_rf.regs[1], 32'd0);
    chk("async_rst_reg6", dut.u_rf.regs[6], 32'd0);
    chk("async_rst_dmem2", dut.dmem[2], 32'd0);
    chk("imem_retained0", dut.imem[0], 32'h2001_0005);
    chk("imem_retained15", dut.imem[15], 32'h0800_0005);
    step();
    rst = 1'b0;
    push_main_trace();
    repeat (15) step();
    load_mem_en = 1'b1;
    chk("rerun_sb_empty", 32'(sb.size()), 32'd0);
    chk("rerun_reg3", dut.u_rf.regs[3], 32'd10);

    // Random image: core must keep running without unknowns.
    for (int i = 0; i < 32; i++) prog[i] = $urandom;
    load_image();
    load_mem_en = 1'b0;
    for (int i = 0; i < 33; i++) begin
      @(negedge clk);
      tests++;
      if ($isunknown({obs_pc, obs_instr, obs_we, obs_waddr, obs_wdata})) begin
        fails++;
        $display("FAIL random_nox: pc=%h instr=%h we=%b waddr=%h wdata=%h", obs_pc, obs_instr, obs_we, obs_waddr, obs_wdata);
      end
      chk("random_pc_align", {30'b0, obs_pc[1:0]}, 32'd0);
    end
    step();
    load_mem_en = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
